// File: rtl/cpu_axi_master_pkg.sv
// ----------------------------------------------------------------------------
// cpu_axi_master_pkg
//
// Shared definitions for the CPU-to-AXI4 initiator:
//   - FSM state encoding (IDLE, AR, R, AW, W, B)
//   - AXI protocol constants (burst type, transfer size, OKAY response)
//   - AXI bus width constants used by the interface and the master
//   - a small helper that classifies an xRESP value as an error
// ----------------------------------------------------------------------------
package cpu_axi_master_pkg;

    // Bus widths of the system AXI fabric
    localparam int AXI_ID_BITS   = 4;   // master-side ID (ARID/AWID)
    localparam int AXI_IDS_BITS  = 8;   // slave-side ID (RID/BID), carries the crossbar prefix
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    // Fixed AXI field values
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;  // 4 bytes per beat
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Transaction FSM
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    // Anything other than OKAY (EXOKAY is never requested, SLVERR/DECERR)
    // is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/cpu_axi_master_if.sv
// ----------------------------------------------------------------------------
// cpu_axi_master_if
//
// The five AXI4 channels between one initiator and the crossbar.
//   master modport : drives AW*, W*, AR*, BREADY, RREADY
//   slave  modport : drives AWREADY, WREADY, B*, ARREADY, R*
// Signal names follow the AXI specification so they line up with the
// existing slave wrappers (WDT, SRAM, DMA).
// ----------------------------------------------------------------------------
interface cpu_axi_master_if;
    import cpu_axi_master_pkg::*;

    // Write address channel
    logic [AXI_ID_BITS-1:0]   AWID;
    logic [AXI_ADDR_BITS-1:0] AWADDR;
    logic [AXI_LEN_BITS-1:0]  AWLEN;
    logic [2:0]               AWSIZE;
    logic [1:0]               AWBURST;
    logic                     AWVALID;
    logic                     AWREADY;

    // Write data channel
    logic [AXI_DATA_BITS-1:0] WDATA;
    logic [AXI_STRB_BITS-1:0] WSTRB;
    logic                     WLAST;
    logic                     WVALID;
    logic                     WREADY;

    // Write response channel
    logic [AXI_IDS_BITS-1:0]  BID;
    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY;

    // Read address channel
    logic [AXI_ID_BITS-1:0]   ARID;
    logic [AXI_ADDR_BITS-1:0] ARADDR;
    logic [AXI_LEN_BITS-1:0]  ARLEN;
    logic [2:0]               ARSIZE;
    logic [1:0]               ARBURST;
    logic                     ARVALID;
    logic                     ARREADY;

    // Read data channel
    logic [AXI_IDS_BITS-1:0]  RID;
    logic [AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]               RRESP;
    logic                     RLAST;
    logic                     RVALID;
    logic                     RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/cpu_axi_master.sv
// ----------------------------------------------------------------------------
// cpu_axi_master
//
// AXI4 initiator for a single core port (IM or DM). Converts a simple
// request/done memory interface into AXI4 INCR read bursts and single-beat
// writes. One transaction is in flight at a time; reads and writes never
// overlap.
//
// Parameters
//   MASTER_ID   constant driven on ARID/AWID
//
// Ports
//   ACLK, ARESETn       clock, asynchronous active-low reset
//   core_req            request strobe, sampled only while idle
//   core_we             1 = write, 0 = read
//   core_addr           word-aligned byte address
//   core_wdata/wstrb    write data and byte strobes
//   core_len            read burst length minus one (ignored for writes)
//   core_busy           a transaction is in progress
//   core_rdata/rvalid   read beat accepted this cycle and its data
//   core_done           one-cycle pulse on the last handshake
//   core_err            qualifies core_done: bad response or beat-count
//                       mismatch
//   axi                 master side of the five AXI channels
// ----------------------------------------------------------------------------
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,

    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [AXI_ADDR_BITS-1:0] core_addr,
    input  logic [AXI_DATA_BITS-1:0] core_wdata,
    input  logic [AXI_STRB_BITS-1:0] core_wstrb,
    input  logic [AXI_LEN_BITS-1:0]  core_len,
    output logic                     core_busy,
    output logic [AXI_DATA_BITS-1:0] core_rdata,
    output logic                     core_rvalid,
    output logic                     core_done,
    output logic                     core_err,

    cpu_axi_master_if.master         axi
);

    state_t                   state;

    // Request latch: holds the core's request for the whole transaction so
    // the AXI payload stays stable while VALID waits for READY.
    logic [AXI_ADDR_BITS-1:0] addr_q;
    logic [AXI_DATA_BITS-1:0] wdata_q;
    logic [AXI_STRB_BITS-1:0] wstrb_q;
    logic [AXI_LEN_BITS-1:0]  len_q;

    // Read bookkeeping
    logic [AXI_LEN_BITS-1:0]  beat_cnt;
    logic                     rresp_err_q;   // sticky over the burst

    // Registered channel controls
    logic                     arvalid_q;
    logic                     rready_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     wlast_q;
    logic                     bready_q;

    logic                     r_hs;
    logic                     b_hs;
    logic                     r_final_err;

    // ------------------------------------------------------------------
    // Transaction FSM. Every VALID/READY is a register that is set on the
    // transition into its state and cleared on the handshake that leaves
    // it, so nothing on the AXI side depends combinationally on a READY.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            rresp_err_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core_req) begin
                        addr_q      <= core_addr;
                        wdata_q     <= core_wdata;
                        wstrb_q     <= core_wstrb;
                        len_q       <= core_len;
                        beat_cnt    <= '0;
                        rresp_err_q <= 1'b0;
                        if (core_we) begin
                            state     <= ST_AW;
                            awvalid_q <= 1'b1;
                        end else begin
                            state     <= ST_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                ST_AR: begin
                    if (axi.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_R;
                    end
                end

                ST_R: begin
                    if (axi.RVALID) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (resp_is_err(axi.RRESP)) begin
                            rresp_err_q <= 1'b1;
                        end
                        // The slave's RLAST terminates the burst; the beat
                        // counter only feeds the error check.
                        if (axi.RLAST) begin
                            rready_q <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end

                ST_AW: begin
                    // W is only offered after AW is accepted: the slaves
                    // latch the address before they will take data.
                    if (axi.AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= 1'b1;
                        state     <= ST_W;
                    end
                end

                ST_W: begin
                    if (axi.WREADY) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= ST_B;
                    end
                end

                ST_B: begin
                    if (axi.BVALID) begin
                        bready_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    wlast_q   <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // AXI channel outputs: Moore, straight from the registers above
    // ------------------------------------------------------------------
    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = '0;            // writes are always single-beat
    assign axi.AWSIZE  = SIZE_WORD;
    assign axi.AWBURST = BURST_INCR;
    assign axi.AWVALID = awvalid_q;

    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = wlast_q;
    assign axi.WVALID  = wvalid_q;

    assign axi.BREADY  = bready_q;

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = SIZE_WORD;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = arvalid_q;

    assign axi.RREADY  = rready_q;

    // ------------------------------------------------------------------
    // Core-side status. rvalid/rdata/done/err follow the current-cycle
    // handshake so the core sees each beat in the cycle it is accepted.
    // ------------------------------------------------------------------
    assign r_hs = (state == ST_R) && axi.RVALID;
    assign b_hs = (state == ST_B) && axi.BVALID;

    // Final-beat error: an earlier bad RRESP, a bad RRESP on this beat, or
    // RLAST showing up on a beat other than the one the request asked for.
    assign r_final_err = rresp_err_q
                       || resp_is_err(axi.RRESP)
                       || (beat_cnt != len_q);

    assign core_busy   = (state != ST_IDLE);
    assign core_rvalid = r_hs;
    assign core_rdata  = (state == ST_R) ? axi.RDATA : '0;
    assign core_done   = (r_hs && axi.RLAST) || b_hs;
    assign core_err    = (r_hs && axi.RLAST && r_final_err)
                       || (b_hs && resp_is_err(axi.BRESP));

    // Response IDs are routed by the crossbar and carry nothing this
    // master needs with one transaction outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi.BID, axi.RID};

endmodule

// File: doc/cpu_axi_master.md
# cpu_axi_master

AXI4 initiator that turns a simple single-request CPU/cache memory interface into AXI4 read bursts and single-beat writes. It sits between a core port (IM or DM) and the AXI crossbar, and drives the master side of the five channels that bus slaves such as the WDT, SRAM and DMA wrappers respond to. Only one transaction is outstanding at a time, and reads and writes are mutually exclusive.

## Interface
Parameters:
- MASTER_ID, default 4'd0: constant driven on ARID/AWID.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset; asynchronous, active-low.
- core_req  in  1  request strobe; sampled only in IDLE.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  32  byte address, word-aligned.
- core_wdata  in  32  write data.
- core_wstrb  in  4  byte strobes for the write.
- core_len  in  4  read burst length minus 1; ignored for writes.
- core_busy  out  1  FSM not in IDLE.
- core_rdata  out  32  read beat data; RDATA passed through.
- core_rvalid  out  1  a read beat is accepted this cycle.
- core_done  out  1  one-cycle pulse on the final handshake of a transaction.
- core_err  out  1  qualifies core_done; response error or beat-count mismatch.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  4/32/4/3/2/1  write address channel.
- AWREADY  in  1  write address ready.
- WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data channel.
- WREADY  in  1  write data ready.
- BID/BRESP/BVALID  in  8/2/1  write response; BID ignored.
- BREADY  out  1  write response ready.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/32/4/3/2/1  read address channel.
- ARREADY  in  1  read address ready.
- RID/RDATA/RRESP/RLAST/RVALID  in  8/32/2/1/1  read data channel; RID ignored.
- RREADY  out  1  read data ready.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE, core_req=1: latch addr, wdata, wstrb, len and clear the beat counter. Go to AW if core_we=1, else AR.
- AR: ARVALID=1, ARADDR = latched address, ARLEN = latched len. On ARREADY go to R.
- R: RREADY=1. core_rvalid = RVALID. Each handshake increments the 4-bit beat counter. On a handshake with RLAST=1, go to IDLE and pulse core_done.
- AW: AWVALID=1, AWLEN=0. On AWREADY go to W. WVALID is never raised before the AW handshake completes, because slaves accept W only after AW.
- W: WVALID=1, WLAST=1, WDATA/WSTRB = latched values. On WREADY go to B.
- B: BREADY=1. On BVALID pulse core_done and go to IDLE.
- Fixed fields: AxSIZE = 3'b010, AxBURST = INCR (2'b01), AxID = MASTER_ID.
- core_err on a read: any beat with RRESP != 0 (sticky within the burst), or RLAST arriving when counter != len. The burst always ends on RLAST, never on the counter value.
- core_err on a write: BRESP != 0.
- A VALID, once raised, stays high with stable payload until its handshake. No abort path exists.
- core_req while busy is ignored; the core holds the request until core_done.

## Timing
- Reset: state = IDLE; all VALID/READY outputs 0; AxADDR, WDATA, WSTRB, AxLEN = 0; WLAST = 0; core_* outputs 0. Reset mid-transaction returns to IDLE immediately and drops all VALIDs.
- All channel outputs are Moore outputs decoded from state and latched registers. There is no combinational path from READY to VALID.
- core_rvalid, core_rdata, core_done and core_err are combinational from the RVALID/BVALID handshake in the current state.
- Minimum latencies with slaves ready immediately (cycle 0 = core_req in IDLE):
  - Single read: ARVALID in cycle 1, R beat in cycle 2 at earliest, core_done in the cycle of the RLAST handshake.
  - Write: AWVALID in cycle 1, WVALID in cycle 2, BREADY in cycle 3, core_done in cycle 3 when BVALID=1.
- Back-to-back: a new core_req is sampled in the IDLE cycle immediately after core_done.

## Structure
- The shared definitions file (def.svh) holds:
  - the state encoding for the six states;
  - AXI constants: BURST_INCR, SIZE_WORD, RESP_OKAY;
  - existing width macros AXI_ID_BITS, AXI_IDS_BITS, AXI_ADDR_BITS, AXI_LEN_BITS, AXI_DATA_BITS, AXI_STRB_BITS.
- Single flat module; no sub-module is natural, since the read and write paths share the FSM and the request latch.

## Test plan
- Single read at 0x1000_0000, len=0, ARREADY delayed 3 cycles, RDATA=0xDEADBEEF -> ARVALID held stable for 4 cycles; core_rvalid and core_done pulse together with rdata=0xDEADBEEF; core_err=0.
- Burst read len=3 with RVALID gaps -> exactly 4 core_rvalid pulses in order; core_done only on the RLAST beat.
- Write 0x0000_1234 with wstrb=4'b0011, WREADY delayed 2 cycles -> WVALID first appears after the AW handshake; WLAST=1 throughout W; core_done on BVALID.
- BRESP=2'b10 on a write, or RRESP=2'b10 on beat 1 of a len=1 read -> core_err=1 with core_done.
- RLAST on beat 2 of a len=3 burst -> transaction ends on that beat with core_err=1.
- ARESETn asserted while in W state -> next cycle all VALIDs are 0 and state is IDLE; a fresh read completes normally afterwards.
